// File: rtl/tl_phase_ctrl.sv
// tl_phase_ctrl: two-street traffic-light phase controller.
// Phases cycle GA -> YA -> GB -> YB -> GA. Green phases last between
// GREEN_MIN and GREEN_MAX cycles depending on cross traffic. Yellow phases
// last YELLOW_LEN cycles.
// Optional pedestrian feature: define TL_PED_EN to enable it. When the macro
// is undefined, ped_req is ignored and walk stays 0.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   Ta, Tb     traffic present on street A / B
//   ped_req    pedestrian request, single-cycle or level
//   La, Lb     lamp codes: 00 green, 01 yellow, 10 red
//   state      current phase: GA=00, YA=01, GB=10, YB=11
//   phase_chg  high for the first cycle of each phase entered after reset
//   walk       high for a whole green phase granted by a pedestrian exit
module tl_phase_ctrl #(
   parameter int unsigned GREEN_MIN  = 4,
   parameter int unsigned GREEN_MAX  = 16,
   parameter int unsigned YELLOW_LEN = 2,
   parameter int unsigned CW         = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Ta,
   input  logic       Tb,
   input  logic       ped_req,
   output logic [1:0] La,
   output logic [1:0] Lb,
   output logic [1:0] state,
   output logic       phase_chg,
   output logic       walk
);

   typedef enum logic [1:0] {
      GA = 2'b00,
      YA = 2'b01,
      GB = 2'b10,
      YB = 2'b11
   } phase_e;

   localparam logic [1:0] LAMP_GREEN  = 2'b00;
   localparam logic [1:0] LAMP_YELLOW = 2'b01;
   localparam logic [1:0] LAMP_RED    = 2'b10;

   localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] GMAX_M1 = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] YLEN_M1 = CW'(YELLOW_LEN - 1);

   phase_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      la_q, la_d;
   logic [1:0]      lb_q, lb_d;
   logic            phase_chg_q, phase_chg_d;
   logic            walk_q, walk_d;
   logic            walk_arm_q, walk_arm_d;

   logic            traffic_c;
   logic            min_ok_c;
   logic            max_hit_c;
   logic            green_exit_c;
   logic            yellow_exit_c;
   logic            ped_exit_c;
   logic            ped_pend_c;

`ifdef TL_PED_EN
   // Pending pedestrian request; dropped (with any same-edge request) on yellow entry
   logic ped_pend_q, ped_pend_d;

   always_comb begin
      ped_pend_d = ped_pend_q | ped_req;
      if (green_exit_c) begin
         ped_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ped_pend_q <= 1'b0;
      end else begin
         ped_pend_q <= ped_pend_d;
      end
   end

   assign ped_pend_c = ped_pend_q;
`else
   logic unused_ped_req;
   assign unused_ped_req = ped_req;
   assign ped_pend_c     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= GA;
         cnt_q       <= '0;
         la_q        <= LAMP_GREEN;
         lb_q        <= LAMP_RED;
         phase_chg_q <= 1'b0;
         walk_q      <= 1'b0;
         walk_arm_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         la_q        <= la_d;
         lb_q        <= lb_d;
         phase_chg_q <= phase_chg_d;
         walk_q      <= walk_d;
         walk_arm_q  <= walk_arm_d;
      end
   end

   // Next-state: phase exit decision and phase timer
   always_comb begin
      state_d       = state_q;
      green_exit_c  = 1'b0;
      yellow_exit_c = 1'b0;
      traffic_c     = (state_q == GB) ? Tb : Ta;
      min_ok_c      = (cnt_q >= GMIN_M1);
      max_hit_c     = (cnt_q == GMAX_M1);
      case (state_q)
         GA, GB: begin
            if (max_hit_c || (min_ok_c && (!traffic_c || ped_pend_c))) begin
               green_exit_c = 1'b1;
            end
         end
         default: begin
            if (cnt_q == YLEN_M1) begin
               yellow_exit_c = 1'b1;
            end
         end
      endcase
      // Exit owed to the pedestrian only: traffic still waiting and max not hit
      ped_exit_c = green_exit_c && !max_hit_c && traffic_c && ped_pend_c;
      if (green_exit_c || yellow_exit_c) begin
         case (state_q)
            GA:      state_d = YA;
            YA:      state_d = GB;
            GB:      state_d = YB;
            default: state_d = GA;
         endcase
      end
      cnt_d = (green_exit_c || yellow_exit_c) ? '0 : cnt_q + CW'(1);
   end

   // Outputs: registered lamp codes, phase pulse and walk for the next phase
   always_comb begin
      la_d        = LAMP_RED;
      lb_d        = LAMP_RED;
      phase_chg_d = green_exit_c | yellow_exit_c;
      walk_d      = walk_q;
      walk_arm_d  = walk_arm_q;
      case (state_d)
         GA:      la_d = LAMP_GREEN;
         YA:      la_d = LAMP_YELLOW;
         GB:      lb_d = LAMP_GREEN;
         default: lb_d = LAMP_YELLOW;
      endcase
      // Walk is armed at a pedestrian-caused green exit and shown during the
      // next green phase, which begins once the intervening yellow ends.
      if (green_exit_c) begin
         walk_d     = 1'b0;
         walk_arm_d = ped_exit_c;
      end else if (yellow_exit_c) begin
         walk_d     = walk_arm_q;
         walk_arm_d = 1'b0;
      end
   end

   assign La        = la_q;
   assign Lb        = lb_q;
   assign state     = state_q;
   assign phase_chg = phase_chg_q;
   assign walk      = walk_q;

endmodule

// File: doc/tl_phase_ctrl.md
TL_PHASE_CTRL -- requirements
Module: tl_phase_ctrl

Interface
REQ-001 The parameter list SHALL be:
- GREEN_MIN, 4, minimum green cycles per phase
- GREEN_MAX, 16, maximum green cycles per phase
- YELLOW_LEN, 2, yellow cycles per phase
- CW, 5, timer counter width
REQ-002 The port list SHALL be:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- Ta  in  1  traffic present on street A
- Tb  in  1  traffic present on street B
- ped_req  in  1  pedestrian request, single-cycle or level
- La  out  2  street A lamp (00 green, 01 yellow, 10 red)
- Lb  out  2  street B lamp, same encoding
- state  out  2  current phase
- phase_chg  out  1  one-cycle pulse in the first cycle of a new phase
- walk  out  1  pedestrian walk indication
REQ-003 Parameters SHALL satisfy 1 <= GREEN_MIN <= GREEN_MAX <= 2^CW-1 and 1 <= YELLOW_LEN <= 2^CW-1.

Function
REQ-004 The phase encoding SHALL be: GA=00 (La green, Lb red), YA=01 (La yellow, Lb red), GB=10 (La red, Lb green), YB=11 (La red, Lb yellow).
REQ-005 Phase order SHALL be GA->YA->GB->YB->GA only; no other transitions.
REQ-006 A CW-bit timer cnt SHALL hold 0 in the first cycle of each phase and increment by 1 each cycle the phase holds; it never wraps, because exits occur before overflow.
REQ-007 GA SHALL exit at the edge where (cnt >= GREEN_MIN-1 and (Ta==0 or ped_pend)) or cnt == GREEN_MAX-1; GB is identical with Tb.
REQ-008 YA/YB SHALL exit at the edge where cnt == YELLOW_LEN-1.
REQ-009 Ta/Tb SHALL be sampled only in their own green phase; values before GREEN_MIN is reached have no effect.
REQ-010 La, Lb, state and phase_chg SHALL be registered and change on the same edge as the phase.
REQ-011 phase_chg SHALL be 1 for exactly the first cycle of every phase except the first cycle after reset.

Reset
REQ-012 While reset=1 at an edge, the block SHALL load: state=GA, cnt=0, La=00, Lb=10, phase_chg=0, walk=0, ped_pend=0.
REQ-013 Reset asserted mid-phase SHALL abandon that phase with no yellow completion; the first cycle after release is GA with cnt=0.

Configuration
REQ-014 Macro TL_PED_EN SHALL enable the pedestrian feature; ports exist in both builds.
REQ-015 With TL_PED_EN, ped_req=1 at an edge SHALL set ped_pend.
REQ-016 With TL_PED_EN, ped_pend SHALL clear on entry to YA or YB; ped_req on that same edge SHALL be dropped.
REQ-017 With TL_PED_EN, an exit caused by ped_pend (traffic still present, max not reached) SHALL set walk=1 for the whole following green phase, clearing on its exit edge.
REQ-018 Without TL_PED_EN, ped_req SHALL be ignored, ped_pend SHALL not exist, and walk SHALL be constant 0.

Verification
REQ-019 Ta=Tb=1 constant after reset -> GA 16 cycles, YA 2, GB 16, YB 2, then repeat with a 36-cycle period; phase_chg pulses at every phase entry.
REQ-020 Ta=0, Tb=1 from reset -> GA 4 cycles, YA 2, GB 16, YB 2, then GA.
REQ-021 Ta=1, dropping to 0 at GA cnt=1 -> GA still lasts 4 cycles (exits at cnt=3); Ta=0 at cnt=7 -> exits at cnt=7.
REQ-022 Reset pulsed during YA cnt=0 -> next cycle state=00, La=00, Lb=10, phase_chg=0, and the following GA lasts the full rule from cnt=0.
REQ-023 TL_PED_EN, Ta=Tb=1, ped_req pulse at GA cnt=2 -> GA exits at cnt=3, walk=1 throughout the next GB (16 cycles), walk=0 in YB.
REQ-024 Without TL_PED_EN, same stimulus -> GA lasts 16 cycles, walk=0 always.
